// File: rtl/cpu_run_ctrl.sv
// Run/debug controller for the 4-bit accumulator core: owns program/data memory,
// sequences core reset, free-run, single-step and halt, and reports why it stopped.
module cpu_run_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CYC_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_cmd_valid,
  output logic              host_cmd_ready,
  input  logic [2:0]        host_cmd,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rdata_valid,
  input  logic              bkpt_en,
  input  logic [ADDR_W-1:0] bkpt_addr,
  input  logic [CYC_W-1:0]  run_limit,
  input  logic [ADDR_W-1:0] cpu_pc,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rst,
  output logic              cpu_ce,
  output logic [1:0]        state,
  output logic [1:0]        halt_cause,
  output logic [CYC_W-1:0]  cycle_count
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [2:0] CMD_LOAD  = 3'd1;
  localparam logic [2:0] CMD_READ  = 3'd2;
  localparam logic [2:0] CMD_RUN   = 3'd3;
  localparam logic [2:0] CMD_STEP  = 3'd4;
  localparam logic [2:0] CMD_HALT  = 3'd5;
  localparam logic [2:0] CMD_CLEAR = 3'd6;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_HOST  = 2'd1;
  localparam logic [1:0] CAUSE_BKPT  = 2'd2;
  localparam logic [1:0] CAUSE_LIMIT = 2'd3;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_HALTED = 2'd1,
    ST_RUN    = 2'd2,
    ST_STEP   = 2'd3
  } state_t;

  state_t              state_reg;
  logic                rst_cnt_reg;
  logic                first_cycle_reg;
  logic [1:0]          halt_cause_reg;
  logic [CYC_W-1:0]    cycle_count_reg;
  logic [DATA_W-1:0]   rdata_reg;
  logic                rdata_valid_reg;
  logic [DATA_W-1:0]   mem_reg [DEPTH];

  logic                cmd_accept;
  logic                halt_acc;
  logic                bkpt_hit;
  logic                limit_hit;
  logic                run_stop;
  logic                core_rst;
  logic                core_ce;
  logic [CYC_W-1:0]    count_next;

  logic                host_load;
  logic                core_write;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DEPTH-1:0]    word_we;

  // While running, only a HALT may be taken so the core never races a host access.
  assign host_cmd_ready = (state_reg != ST_RESET) &&
                          ((state_reg != ST_RUN) || (host_cmd == CMD_HALT));
  assign cmd_accept = host_cmd_valid && host_cmd_ready;

  assign halt_acc  = (state_reg == ST_RUN) && cmd_accept && (host_cmd == CMD_HALT);
  assign bkpt_hit  = bkpt_en && (cpu_pc == bkpt_addr) && !first_cycle_reg;
  assign limit_hit = (run_limit != '0) && (cycle_count_reg == run_limit);
  assign run_stop  = halt_acc || bkpt_hit || limit_hit;

  assign count_next = (&cycle_count_reg) ? cycle_count_reg : cycle_count_reg + CYC_W'(1);

  always_comb begin
    core_rst = 1'b0;
    core_ce  = 1'b0;
    case (state_reg)
      ST_RESET: begin
        core_rst = 1'b1;
        core_ce  = 1'b1;
      end
      ST_HALTED: begin
        core_rst = 1'b0;
        core_ce  = 1'b0;
      end
      ST_RUN:  core_ce = !run_stop;
      ST_STEP: core_ce = 1'b1;
    endcase
  end

  assign cpu_rst = core_rst;
  assign cpu_ce  = core_ce;

  // Host loads only happen while halted and the core only writes while enabled,
  // so a single write port suffices.
  assign host_load  = (state_reg == ST_HALTED) && cmd_accept && (host_cmd == CMD_LOAD);
  assign core_write = core_ce && cpu_we && !core_rst;
  assign mem_we     = host_load || core_write;
  assign mem_waddr  = host_load ? host_addr : cpu_addr;
  assign mem_wdata  = host_load ? host_wdata : cpu_wdata;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word_we
      assign word_we[gi] = mem_we && (mem_waddr == ADDR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (word_we[i]) mem_reg[i] <= mem_wdata;
      end
    end
  end

  assign cpu_rdata = mem_reg[cpu_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_RESET;
      rst_cnt_reg     <= 1'b0;
      first_cycle_reg <= 1'b0;
      halt_cause_reg  <= CAUSE_NONE;
      cycle_count_reg <= '0;
      rdata_reg       <= '0;
      rdata_valid_reg <= 1'b0;
    end else begin
      rdata_valid_reg <= 1'b0;
      case (state_reg)
        ST_RESET: begin
          // Two core-reset cycles: counter 0 then 1, then release.
          rst_cnt_reg <= !rst_cnt_reg;
          if (rst_cnt_reg) state_reg <= ST_HALTED;
        end
        ST_HALTED: begin
          if (cmd_accept) begin
            case (host_cmd)
              CMD_READ: begin
                rdata_reg       <= mem_reg[host_addr];
                rdata_valid_reg <= 1'b1;
              end
              CMD_RUN: begin
                cycle_count_reg <= '0;
                first_cycle_reg <= 1'b1;
                state_reg       <= ST_RUN;
              end
              CMD_STEP: state_reg <= ST_STEP;
              CMD_CLEAR: begin
                cycle_count_reg <= '0;
                halt_cause_reg  <= CAUSE_NONE;
                rst_cnt_reg     <= 1'b0;
                state_reg       <= ST_RESET;
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          first_cycle_reg <= 1'b0;
          if (run_stop) begin
            state_reg <= ST_HALTED;
            if (halt_acc)      halt_cause_reg <= CAUSE_HOST;
            else if (bkpt_hit) halt_cause_reg <= CAUSE_BKPT;
            else               halt_cause_reg <= CAUSE_LIMIT;
          end else begin
            cycle_count_reg <= count_next;
          end
        end
        ST_STEP: begin
          cycle_count_reg <= count_next;
          halt_cause_reg  <= CAUSE_HOST;
          state_reg       <= ST_HALTED;
        end
      endcase
    end
  end

  assign state            = state_reg;
  assign halt_cause       = halt_cause_reg;
  assign cycle_count      = cycle_count_reg;
  assign host_rdata       = rdata_reg;
  assign host_rdata_valid = rdata_valid_reg;

endmodule
